// File: rtl/dnn_result_reader.sv
// Reads the inference engine's output layer after a classification run and
// reports the winning neuron (argmax of the signed scores). A run soft-resets
// the engine, starts it, waits (bounded) for completion, then scans every
// output neuron once, keeping the running maximum with ties going to the
// lowest index.
module dnn_result_reader #(
  parameter int DATA_WIDTH  = 11,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  busy,
  output logic                  eng_reset,
  output logic                  eng_start,
  input  logic                  eng_done,
  output logic [3:0]            out_idx,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            class_out,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  class_valid,
  output logic                  class_err
);

  // Wait counter only has to represent 0..TIMEOUT-1; the abort fires on the
  // edge that would otherwise take it to TIMEOUT.
  localparam int              CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [3:0]      IDX_LAST = 4'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    SCAN  = 3'd4
  } state_t;

  state_t                        state_reg;
  logic [CW-1:0]                 wait_cnt_reg;
  logic signed [DATA_WIDTH-1:0]  max_score_reg;
  logic [3:0]                    max_idx_reg;

  logic                          take_new;
  logic signed [DATA_WIDTH-1:0]  new_score;
  logic [3:0]                    new_idx;

  // Running-max update for the neuron currently selected by out_idx; index 0
  // always seeds the maximum, later indices need a strictly greater score.
  always_comb begin
    take_new  = (out_idx == 4'd0) || ($signed(out_data) > max_score_reg);
    new_score = take_new ? $signed(out_data) : max_score_reg;
    new_idx   = take_new ? out_idx : max_idx_reg;
  end

  // Control FSM; every output is a register updated together with the state
  // so that pulses line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      busy          <= 1'b0;
      eng_reset     <= 1'b0;
      eng_start     <= 1'b0;
      out_idx       <= 4'd0;
      class_out     <= 4'd0;
      class_score   <= '0;
      class_valid   <= 1'b0;
      class_err     <= 1'b0;
      wait_cnt_reg  <= '0;
      max_score_reg <= '0;
      max_idx_reg   <= 4'd0;
    end else begin
      eng_reset <= 1'b0;
      eng_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (run) begin
            state_reg   <= CLR;
            busy        <= 1'b1;
            eng_reset   <= 1'b1;
            class_valid <= 1'b0;
            class_err   <= 1'b0;
          end
        end
        CLR: begin
          state_reg <= START;
          eng_start <= 1'b1;
        end
        START: begin
          state_reg    <= WAIT;
          wait_cnt_reg <= '0;
        end
        WAIT: begin
          if (eng_done) begin
            state_reg <= SCAN;
            out_idx   <= 4'd0;
          end else if (wait_cnt_reg == CNT_LAST) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            class_err   <= 1'b1;
            class_valid <= 1'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        SCAN: begin
          max_score_reg <= new_score;
          max_idx_reg   <= new_idx;
          if (out_idx == IDX_LAST) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            out_idx     <= 4'd0;
            class_out   <= new_idx;
            class_score <= new_score;
            class_valid <= 1'b1;
          end else begin
            out_idx <= out_idx + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          out_idx   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dnn_result_reader.sv
// Self-checking bench for dnn_result_reader: a behavioural engine (score
// table indexed by out_idx) plus an argmax reference model.
module tb_dnn_result_reader;
  localparam int DW  = 11;
  localparam int NC  = 10;
  // Negedges from raising eng_done to seeing class_valid: one edge samples
  // eng_done, then NC edges scan the neurons.
  localparam int LAT = NC + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, run, eng_done;
  logic          busy, eng_reset, eng_start;
  logic [3:0]    out_idx, class_out;
  logic [DW-1:0] out_data, class_score;
  logic          class_valid, class_err;

  logic          run_t, done_t;
  logic          busy_t, eng_reset_t, eng_start_t;
  logic [3:0]    out_idx_t, class_out_t;
  logic [DW-1:0] data_t, class_score_t;
  logic          class_valid_t, class_err_t;

  int sc [NC];
  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  int reset_cnt = 0;

  assign out_data = (out_idx < 4'(NC)) ? DW'(sc[out_idx]) : '0;
  assign data_t   = '0;

  dnn_result_reader dut (
    .clk(clk), .rst(rst), .run(run), .busy(busy), .eng_reset(eng_reset),
    .eng_start(eng_start), .eng_done(eng_done), .out_idx(out_idx),
    .out_data(out_data), .class_out(class_out), .class_score(class_score),
    .class_valid(class_valid), .class_err(class_err)
  );

  dnn_result_reader #(.TIMEOUT(20)) dut_t (
    .clk(clk), .rst(rst), .run(run_t), .busy(busy_t), .eng_reset(eng_reset_t),
    .eng_start(eng_start_t), .eng_done(done_t), .out_idx(out_idx_t),
    .out_data(data_t), .class_out(class_out_t), .class_score(class_score_t),
    .class_valid(class_valid_t), .class_err(class_err_t)
  );

  // Continuous invariants and engine pulse counting.
  always @(negedge clk) begin
    if (rst) begin
      tests++;
      if (out_idx >= 4'(NC) || (eng_start && eng_reset) ||
          (!busy && (out_idx != 4'd0 || eng_start || eng_reset))) begin
        fails++;
        $display("FAIL invariant: out_idx=%0d eng_start=%b eng_reset=%b busy=%b (need idx<%0d, pulses exclusive, idle quiet)",
                 out_idx, eng_start, eng_reset, busy, NC);
      end
      if (eng_start) start_cnt++;
      if (eng_reset) reset_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_model(output int idx, output int best);
    idx  = 0;
    best = sc[0];
    for (int i = 1; i < NC; i++)
      if (sc[i] > best) begin
        best = sc[i];
        idx  = i;
      end
  endfunction

  // Drives one run on the main instance and returns the eng_done-to-valid latency.
  task automatic do_run(input int dly, input bit noise, input bit drop, output int lat);
    int n;
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    n = 0;
    while (!eng_start && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (eng_start !== 1'b1) begin
      fails++; $display("FAIL start_wait: eng_start=%b required 1", eng_start);
    end
    repeat (dly) begin
      @(negedge clk);
      if (noise) run = 1'($urandom_range(0, 1));
    end
    eng_done = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); n++;
      run = 1'b0;
      if (class_valid || n > 40) break;
      tests++;
      if (out_idx !== 4'(n - 1) || busy !== 1'b1) begin
        fails++; $display("FAIL scan_idx: out_idx=%0d busy=%b required %0d/1", out_idx, busy, n - 1);
      end
      if (noise) run = 1'($urandom_range(0, 1));
      if (drop && n == 3) eng_done = 1'b0;
    end
    eng_done = 1'b0;
    lat = n;
  endtask

  task automatic test_reset();
    int s, r;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, eng_reset, eng_start, class_valid, class_err} !== 5'b0 || out_idx !== 4'd0 ||
        class_out !== 4'd0 || class_score !== '0 || class_err_t !== 1'b0) begin
      fails++; $display("FAIL reset_state: busy=%b rst=%b st=%b v=%b e=%b idx=%0d cls=%0d sc=%0d required all 0",
                        busy, eng_reset, eng_start, class_valid, class_err, out_idx, class_out, class_score);
    end
    run = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_run: busy=%b required 0", busy); end
    run = 1'b0;
    rst = 1'b1;
    s = start_cnt; r = reset_cnt;
    repeat (5) @(negedge clk);
    tests++;
    if (start_cnt != s || reset_cnt != r || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset_quiet: starts=%0d resets=%0d busy=%b required 0 0 0",
                        start_cnt - s, reset_cnt - r, busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    int lat, s, r, gs;
    sc = '{5, -3, 100, 7, 100, 0, -50, 2, 99, -1};
    s = start_cnt; r = reset_cnt;
    do_run(4, 1'b0, 1'b0, lat);
    gs = $signed(class_score);
    tests++;
    if (lat != LAT) begin fails++; $display("FAIL directed_latency: got %0d required %0d", lat, LAT); end
    tests++;
    if (class_out !== 4'd2 || gs != 100 || class_valid !== 1'b1 || class_err !== 1'b0) begin
      fails++; $display("FAIL directed_result: class=%0d score=%0d v=%b e=%b required 2 100 1 0",
                        class_out, gs, class_valid, class_err);
    end
    tests++;
    if (start_cnt - s != 1 || reset_cnt - r != 1) begin
      fails++; $display("FAIL directed_pulses: starts=%0d resets=%0d required 1 1", start_cnt - s, reset_cnt - r);
    end
    repeat (5) @(negedge clk);
    gs = $signed(class_score);
    tests++;
    if (class_out !== 4'd2 || gs != 100 || class_valid !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_hold: class=%0d score=%0d v=%b busy=%b required 2 100 1 0",
                        class_out, gs, class_valid, busy);
    end
    $display("[TB] directed run class=%0d score=%0d latency=%0d", class_out, gs, lat);
  endtask

  task automatic test_extremes();
    int lat, gs;
    for (int i = 0; i < NC; i++) sc[i] = -1024;
    do_run(2, 1'b0, 1'b0, lat);
    gs = $signed(class_score);
    tests++;
    if (class_out !== 4'd0 || gs != -1024 || class_valid !== 1'b1) begin
      fails++; $display("FAIL all_min: class=%0d score=%0d v=%b required 0 -1024 1", class_out, gs, class_valid);
    end
    $display("[TB] all-min run class=%0d score=%0d", class_out, gs);
    for (int i = 0; i < NC; i++) sc[i] = 0;
    sc[NC-1] = 1;
    do_run(1, 1'b0, 1'b0, lat);
    gs = $signed(class_score);
    tests++;
    if (class_out !== 4'(NC - 1) || gs != 1) begin
      fails++; $display("FAIL last_wins: class=%0d score=%0d required %0d 1", class_out, gs, NC - 1);
    end
    $display("[TB] last-index run class=%0d score=%0d", class_out, gs);
  endtask

  task automatic test_random();
    int lat, s, r, gs, eidx, ebest, mode;
    bit noise, drop;
    for (int it = 0; it < 30; it++) begin
      mode = int'($urandom_range(0, 2));
      for (int i = 0; i < NC; i++)
        sc[i] = (mode == 0) ? int'($urandom_range(0, 3)) - 1 :
                (mode == 1) ? int'($urandom_range(1020, 1023)) * ((i % 2 == 0) ? 1 : -1) :
                              int'($urandom_range(0, 2047)) - 1024;
      ref_model(eidx, ebest);
      noise = 1'($urandom_range(0, 1));
      drop  = 1'($urandom_range(0, 1));
      s = start_cnt; r = reset_cnt;
      do_run(int'($urandom_range(1, 12)), noise, drop, lat);
      gs = $signed(class_score);
      tests++;
      if (class_out !== 4'(eidx) || gs != ebest || class_valid !== 1'b1 || class_err !== 1'b0 || lat != LAT) begin
        fails++; $display("FAIL random_run %0d: class=%0d score=%0d v=%b e=%b lat=%0d required %0d %0d 1 0 %0d",
                          it, class_out, gs, class_valid, class_err, lat, eidx, ebest, LAT);
      end
      tests++;
      if (start_cnt - s != 1 || reset_cnt - r != 1) begin
        fails++; $display("FAIL random_pulses %0d: starts=%0d resets=%0d required 1 1", it, start_cnt - s, reset_cnt - r);
      end
      $display("[TB] random run %0d noise=%0b drop=%0b class=%0d score=%0d expected %0d %0d",
               it, noise, drop, class_out, gs, eidx, ebest);
    end
  endtask

  task automatic test_back_to_back();
    int n, s, gs, eidx, ebest;
    for (int i = 0; i < NC; i++) sc[i] = int'($urandom_range(0, 2047)) - 1024;
    ref_model(eidx, ebest);
    s = start_cnt;
    @(negedge clk); run = 1'b1;
    n = 0;
    while (!eng_start && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    eng_done = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!class_valid && n < 40);
    eng_done = 1'b0;
    gs = $signed(class_score);
    tests++;
    if (n != LAT || class_out !== 4'(eidx) || gs != ebest || busy !== 1'b0) begin
      fails++; $display("FAIL b2b_first: lat=%0d class=%0d score=%0d busy=%b required %0d %0d %0d 0",
                        n, class_out, gs, busy, LAT, eidx, ebest);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || eng_reset !== 1'b1) begin
      fails++; $display("FAIL b2b_restart: busy=%b eng_reset=%b required 1 1 after one idle cycle", busy, eng_reset);
    end
    run = 1'b0;
    for (int i = 0; i < NC; i++) sc[i] = int'($urandom_range(0, 2047)) - 1024;
    ref_model(eidx, ebest);
    n = 0;
    while (!eng_start && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    eng_done = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!class_valid && n < 40);
    eng_done = 1'b0;
    gs = $signed(class_score);
    tests++;
    if (n != LAT || class_out !== 4'(eidx) || gs != ebest || start_cnt - s != 2) begin
      fails++; $display("FAIL b2b_second: lat=%0d class=%0d score=%0d starts=%0d required %0d %0d %0d 2",
                        n, class_out, gs, start_cnt - s, LAT, eidx, ebest);
    end
    $display("[TB] back-to-back runs class=%0d score=%0d starts=%0d", class_out, gs, start_cnt - s);
  endtask

  task automatic test_reset_midscan();
    int n, s, r, lat, gs;
    sc = '{5, -3, 100, 7, 100, 0, -50, 2, 99, -1};
    @(negedge clk); run = 1'b1;
    @(negedge clk); run = 1'b0;
    n = 0;
    while (!eng_start && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    eng_done = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (out_idx != 4'd5 && n < 20);
    tests++;
    if (out_idx !== 4'd5) begin fails++; $display("FAIL midscan_reach: out_idx=%0d required 5", out_idx); end
    rst = 1'b0;
    #1;
    tests++;
    if ({busy, eng_reset, eng_start, class_valid, class_err} !== 5'b0 || out_idx !== 4'd0 ||
        class_out !== 4'd0 || class_score !== '0) begin
      fails++; $display("FAIL midscan_reset: busy=%b v=%b e=%b idx=%0d cls=%0d sc=%0d required all 0",
                        busy, class_valid, class_err, out_idx, class_out, class_score);
    end
    eng_done = 1'b0;
    @(negedge clk); rst = 1'b1;
    s = start_cnt; r = reset_cnt;
    repeat (4) @(negedge clk);
    tests++;
    if (start_cnt != s || reset_cnt != r || busy !== 1'b0) begin
      fails++; $display("FAIL midscan_quiet: starts=%0d resets=%0d busy=%b required 0 0 0",
                        start_cnt - s, reset_cnt - r, busy);
    end
    do_run(4, 1'b0, 1'b0, lat);
    gs = $signed(class_score);
    tests++;
    if (class_out !== 4'd2 || gs != 100 || lat != LAT || class_valid !== 1'b1) begin
      fails++; $display("FAIL midscan_rerun: class=%0d score=%0d lat=%0d v=%b required 2 100 %0d 1",
                        class_out, gs, lat, class_valid, LAT);
    end
    $display("[TB] reset mid-scan then rerun class=%0d score=%0d", class_out, gs);
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk); run_t = 1'b1;
    @(negedge clk); run_t = 1'b0;
    @(negedge clk);
    tests++;
    if (eng_start_t !== 1'b1) begin fails++; $display("FAIL timeout_start: eng_start=%b required 1", eng_start_t); end
    n = 0;
    do begin @(negedge clk); n++; end while (busy_t && n < 100);
    tests++;
    if (n - 1 != 20 || class_err_t !== 1'b1 || class_valid_t !== 1'b0 || busy_t !== 1'b0) begin
      fails++; $display("FAIL timeout_abort: wait_cycles=%0d err=%b v=%b busy=%b required 20 1 0 0",
                        n - 1, class_err_t, class_valid_t, busy_t);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (class_err_t !== 1'b1) begin fails++; $display("FAIL timeout_hold: err=%b required 1", class_err_t); end
    $display("[TB] timeout run wait_cycles=%0d err=%0b", n - 1, class_err_t);
    // Done raised in the last permitted WAIT cycle must still win over the abort.
    @(negedge clk); run_t = 1'b1;
    @(negedge clk); run_t = 1'b0;
    @(negedge clk);
    repeat (20) @(negedge clk);
    done_t = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!class_valid_t && n < 40);
    done_t = 1'b0;
    tests++;
    if (class_valid_t !== 1'b1 || class_err_t !== 1'b0 || n != LAT || class_out_t !== 4'd0) begin
      fails++; $display("FAIL timeout_edge_done: v=%b err=%b lat=%0d class=%0d required 1 0 %0d 0",
                        class_valid_t, class_err_t, n, class_out_t, LAT);
    end
    $display("[TB] late-done run valid=%0b err=%0b", class_valid_t, class_err_t);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; eng_done = 1'b0; run_t = 1'b0; done_t = 1'b0;
    for (int i = 0; i < NC; i++) sc[i] = 0;
    test_reset();
    test_directed();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_midscan();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dnn_result_reader.md
DNN_RESULT_READER -- requirements
Module: dnn_result_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 11, width of the engine output score word (signed fixed point).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of engine output neurons, indices 0..NUM_CLASSES-1.
REQ-003 SHALL have parameter TIMEOUT, default 65535, the maximum number of WAIT cycles before an error abort.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 run  input  1  request one classification; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 eng_reset  output  1  soft-reset pulse to the inference engine.
REQ-009 eng_start  output  1  start pulse to the inference engine.
REQ-010 eng_done  input  1  engine completion level.
REQ-011 out_idx  output  4  unsigned output-neuron select driven to the engine.
REQ-012 out_data  input  DATA_WIDTH  signed score of the selected neuron; combinational from out_idx, same cycle.
REQ-013 class_out  output  4  index of the winning neuron.
REQ-014 class_score  output  DATA_WIDTH  signed score of the winning neuron.
REQ-015 class_valid  output  1  high while class_out and class_score hold a completed result.
REQ-016 class_err  output  1  high while the last run ended in a timeout.

Function
REQ-017 FSM states SHALL be IDLE, CLR, START, WAIT and SCAN, and the FSM SHALL be in IDLE out of reset.
REQ-018 IDLE: run=1 -> CLR; class_valid, class_err, class_out and class_score SHALL hold their values.
REQ-019 CLR: eng_reset=1 for exactly this one cycle; class_valid and class_err cleared to 0; next state START.
REQ-020 START: eng_start=1 for exactly this one cycle; WAIT counter cleared to 0; next state WAIT.
REQ-021 WAIT: eng_done=1 -> SCAN with scan index 0; otherwise increment counter; counter reaching TIMEOUT without eng_done -> IDLE with class_err=1, class_valid=0.
REQ-022 SCAN: out_idx SHALL equal the scan index; out_data SHALL be sampled in that same cycle; the scan index SHALL advance by 1 per cycle, for exactly NUM_CLASSES cycles.
REQ-023 Index 0 SHALL unconditionally load the running maximum and its index; index k>0 SHALL replace them only if out_data > running max (strict signed compare), so ties resolve to the lowest index.
REQ-024 The edge that samples index NUM_CLASSES-1 SHALL write class_out and class_score (including that final compare), set class_valid=1 and go to IDLE.
REQ-025 Latency: class_valid SHALL rise NUM_CLASSES rising edges after the edge at which eng_done is sampled high in WAIT (10 for defaults).
REQ-026 out_idx SHALL be 0 in every state other than SCAN.
REQ-027 run SHALL be ignored whenever busy=1; run held high SHALL start a new run on the cycle IDLE is re-entered.
REQ-028 eng_done deasserting during SCAN SHALL be ignored, and the scan SHALL complete.
REQ-029 eng_reset and eng_start SHALL never be high in the same cycle.
REQ-030 Scores SHALL be compared at full DATA_WIDTH signed precision with no truncation or saturation.

Reset
REQ-031 rst=0 SHALL immediately force IDLE with busy, eng_reset, eng_start, class_valid and class_err all 0, and out_idx, class_out, class_score, the scan index and the WAIT counter all 0, including mid-run.
REQ-032 After rst is released, no engine pulse SHALL issue until a new run is sampled in IDLE.

Verification
REQ-033 Scores {5,-3,100,7,100,0,-50,2,99,-1}, run pulse, eng_done 4 cycles after eng_start -> eng_reset and eng_start each pulse once, class_out=2, class_score=100, class_valid high 10 edges after eng_done is sampled.
REQ-034 All scores -1024 (min 11-bit) -> class_out=0, class_score=-1024; scores all 0 except index 9 = 1 -> class_out=9.
REQ-035 TIMEOUT=20 and eng_done never asserted -> IDLE after 20 WAIT cycles, class_err=1, class_valid=0, busy=0.
REQ-036 run pulsed during WAIT and SCAN -> no extra eng_start; exactly one result; run held high -> back-to-back runs with a single IDLE cycle between them.
REQ-037 rst=0 asserted at scan index 5 -> all outputs zero immediately; after release, a new run completes correctly with the REQ-033 data.
REQ-038 Assertion checks: out_idx < NUM_CLASSES at all times, eng_start and eng_reset never both high, busy=0 only in IDLE.
